// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// UART_FRAME_TX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_FRAME_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4,
        StGap    = 3'd5
    } uart_state_e;

    // Counter width for values 0..n-1; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                res = i + 1;
            end
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Baud counter plus single-byte serialiser: START, DATA, optional PARITY, STOP.
// byte_done is high in the last cycle of the stop bit; a load in that cycle chains seamlessly.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int unsigned CntW = clog2(DIV);

    uart_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntW'(DIV - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        byte_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                tx_d  = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_FRAME_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = ^shift_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_d];
                    end
                end
            end
`ifdef UART_FRAME_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    byte_done = 1'b1;
                    state_d   = StIdle;
                    tx_d      = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            state_d = StStart;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = byte_in;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: latches N_BYTES on start, sends byte 0 first, pulses done.
// Define UART_FRAME_TX_PARITY_EN for 8E1 framing instead of 8N1.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned N_BYTES  = 5,
    parameter int unsigned GAP_BITS = 0
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*N_BYTES-1:0]   data,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned DIV       = CLK_FREQ / BAUD;
    localparam int unsigned IdxW      = clog2(N_BYTES);
    localparam int unsigned GapCycles = GAP_BITS * DIV;
    localparam int unsigned GapW      = clog2(GapCycles + 1);

    // Top-level phase: StData means a byte is owned by the serialiser.
    uart_state_e          state_q, state_d;
    logic [8*N_BYTES-1:0] data_q, data_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [GapW-1:0]      gap_q, gap_d;
    logic                 done_q, done_d;
    logic                 load;
    logic [7:0]           byte_sel;
    logic                 byte_done;
    logic                 last_byte;

    assign last_byte = (idx_q == IdxW'(N_BYTES - 1));

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        load     = 1'b0;
        byte_sel = data_q[{idx_q, 3'b000} +: 8];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d   = data;
                    idx_d    = '0;
                    load     = 1'b1;
                    byte_sel = data[7:0];
                    state_d  = StData;
                end
            end
            StData: begin
                if (byte_done) begin
                    if (last_byte) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (GAP_BITS == 0) begin
                            load     = 1'b1;
                            byte_sel = data_q[{idx_d, 3'b000} +: 8];
                        end else begin
                            gap_d   = '0;
                            state_d = StGap;
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q == GapW'(GapCycles - 1)) begin
                    gap_d   = '0;
                    load    = 1'b1;
                    state_d = StData;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    uart_byte_tx #(
        .DIV (DIV)
    ) u_byte_tx (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .load      (load),
        .byte_in   (byte_sel),
        .tx        (uart_tx),
        .byte_done (byte_done)
    );

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: three instances (5-byte, 2-byte with gap, 1-byte)
// decoded by line monitors against a byte scoreboard, plus frame timing checks.
module tb_uart_frame_tx;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int          DIV      = 10;
`ifdef UART_FRAME_TX_PARITY_EN
    localparam int          F        = 11;
`else
    localparam int          F        = 10;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start5  = 1'b0, start2 = 1'b0, start1 = 1'b0;
    logic [39:0] data5   = '0;
    logic [15:0] data2   = '0;
    logic [7:0]  data1   = '0;
    logic        tx5, busy5, done5;
    logic        tx2, busy2, done2;
    logic        tx1, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt5 = 0, done_cnt2 = 0;

    logic [7:0] exp5[$];
    logic [7:0] exp2[$];
    logic [7:0] exp1[$];

    typedef struct {
        logic [39:0]     data;
        logic [4:0][7:0] exp;
    } vec_t;

    always #5 sys_clk = ~sys_clk;

    uart_frame_tx #(
        .CLK_FREQ (CLK_FREQ), .BAUD (BAUD), .N_BYTES (5), .GAP_BITS (0)
    ) u_dut5 (
        .sys_clk (sys_clk), .rst_n (rst_n), .start (start5), .data (data5),
        .uart_tx (tx5), .busy (busy5), .done (done5)
    );

    uart_frame_tx #(
        .CLK_FREQ (CLK_FREQ), .BAUD (BAUD), .N_BYTES (2), .GAP_BITS (3)
    ) u_dut2 (
        .sys_clk (sys_clk), .rst_n (rst_n), .start (start2), .data (data2),
        .uart_tx (tx2), .busy (busy2), .done (done2)
    );

    uart_frame_tx #(
        .CLK_FREQ (CLK_FREQ), .BAUD (BAUD), .N_BYTES (1), .GAP_BITS (0)
    ) u_dut1 (
        .sys_clk (sys_clk), .rst_n (rst_n), .start (start1), .data (data1),
        .uart_tx (tx1), .busy (busy1), .done (done1)
    );

    always @(negedge sys_clk) begin
        if (done5) done_cnt5 <= done_cnt5 + 1;
        if (done2) done_cnt2 <= done_cnt2 + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic tx_of(input int w);
        case (w)
            5:       return tx5;
            2:       return tx2;
            default: return tx1;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            5:       return busy5;
            2:       return busy2;
            default: return busy1;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            5:       return done5;
            2:       return done2;
            default: return done1;
        endcase
    endfunction

    task automatic set_in(input int w, input logic s, input logic [39:0] d);
        case (w)
            5:       begin start5 = s; data5 = d;       end
            2:       begin start2 = s; data2 = d[15:0]; end
            default: begin start1 = s; data1 = d[7:0];  end
        endcase
    endtask

    task automatic wait_neg(input int n, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            if (!rst_n) aborted = 1'b1;
        end
    endtask

    // Decode one character from the line, sampling mid-bit; gives up on reset.
    task automatic mon_byte(input int w, output bit got, output logic [7:0] b,
                            output logic sb, output logic par, output logic stp);
        bit ab;
        got = 1'b0; b = '0; sb = 1'b1; par = 1'b0; stp = 1'b0;
        do @(negedge sys_clk); while (!(rst_n && tx_of(w) == 1'b0));
        wait_neg(DIV / 2, ab);
        if (ab) return;
        sb = tx_of(w);
        for (int i = 0; i < 8; i++) begin
            wait_neg(DIV, ab);
            if (ab) return;
            b[i] = tx_of(w);
        end
`ifdef UART_FRAME_TX_PARITY_EN
        wait_neg(DIV, ab);
        if (ab) return;
        par = tx_of(w);
`endif
        wait_neg(DIV, ab);
        if (ab) return;
        stp = tx_of(w);
        got = 1'b1;
    endtask

    task automatic score(input int w, input logic [7:0] b, input logic sb,
                         input logic par, input logic stp);
        int         sz;
        logic [7:0] e;
        sz = (w == 5) ? exp5.size() : (w == 2) ? exp2.size() : exp1.size();
        if (sz == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte dut%0d: got 0x%0h, expected none", w, b);
            return;
        end
        e = (w == 5) ? exp5.pop_front() : (w == 2) ? exp2.pop_front() : exp1.pop_front();
        check($sformatf("rx_byte_dut%0d", w), b, e);
        check($sformatf("start_bit_dut%0d", w), sb, 0);
        check($sformatf("stop_bit_dut%0d", w), stp, 1);
`ifdef UART_FRAME_TX_PARITY_EN
        check($sformatf("parity_dut%0d", w), par, ^e);
`endif
    endtask

    always begin : mon_5
        bit got; logic [7:0] b; logic sb, p, s;
        mon_byte(5, got, b, sb, p, s);
        if (got) score(5, b, sb, p, s);
    end

    always begin : mon_2
        bit got; logic [7:0] b; logic sb, p, s;
        mon_byte(2, got, b, sb, p, s);
        if (got) score(2, b, sb, p, s);
    end

    always begin : mon_1
        bit got; logic [7:0] b; logic sb, p, s;
        mon_byte(1, got, b, sb, p, s);
        if (got) score(1, b, sb, p, s);
    end

    // One-cycle start pulse, then time the frame up to the done pulse.
    task automatic run_frame(input int w, input logic [39:0] d, input int exp_done);
        int n;
        bit seen, busy_drop;
        set_in(w, 1'b1, d);
        @(negedge sys_clk);
        set_in(w, 1'b0, d);
        check("start_latency_tx", tx_of(w), 0);
        check("start_latency_busy", busy_of(w), 1);
        n = 1; seen = 1'b0; busy_drop = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge sys_clk);
            n++;
            if (done_of(w)) seen = 1'b1;
            else if (!busy_of(w)) busy_drop = 1'b1;
        end
        check("done_cycle", seen ? n : -1, exp_done);
        check("busy_held", busy_drop, 0);
        check("done_busy_low", busy_of(w), 0);
        check("done_tx_high", tx_of(w), 1);
        @(negedge sys_clk);
        check("done_one_cycle", done_of(w), 0);
    endtask

    initial begin
        vec_t vecs[4];
        int   n, dc;
        bit   seen, idle_bad;

        vecs[0] = '{data: 40'h10_08_04_02_01, exp: {8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};
        vecs[1] = '{data: 40'hFF_00_A5_5A_80, exp: {8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h80}};
        vecs[2] = '{data: 40'h00_00_00_00_00, exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{data: 40'h12_34_56_78_9A, exp: {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A}};

        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;

        idle_bad = 1'b0;
        repeat (100) begin
            @(negedge sys_clk);
            for (int w = 1; w <= 5; w++) begin
                if (w == 1 || w == 2 || w == 5) begin
                    if (tx_of(w) !== 1'b1 || busy_of(w) !== 1'b0 || done_of(w) !== 1'b0)
                        idle_bad = 1'b1;
                end
            end
        end
        check("idle_quiet", idle_bad, 0);

        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < 5; j++) exp5.push_back(vecs[v].exp[j]);
            run_frame(5, vecs[v].data, 5 * F * DIV + 1);
            repeat (3) @(negedge sys_clk);
            check("sb_drained_dut5", exp5.size(), 0);
        end

        // Two bytes with a 3-bit idle gap.
        exp2.push_back(8'h07);
        exp2.push_back(8'h03);
        run_frame(2, 40'h0307, (2 * F + 3) * DIV + 1);
        repeat (3) @(negedge sys_clk);
        check("sb_drained_gap", exp2.size(), 0);

        // A start pulse while busy must be ignored.
        exp2.push_back(8'h07);
        exp2.push_back(8'h03);
        dc = done_cnt2;
        set_in(2, 1'b1, 40'h0307);
        @(negedge sys_clk);
        set_in(2, 1'b0, 40'h0307);
        repeat (50) @(negedge sys_clk);
        check("ignore_busy_mid", busy2, 1);
        set_in(2, 1'b1, 40'hAAAA);
        @(negedge sys_clk);
        set_in(2, 1'b0, 40'hAAAA);
        repeat (600) @(negedge sys_clk);
        check("ignore_done_count", done_cnt2 - dc, 1);
        check("ignore_sb_drained", exp2.size(), 0);
        check("ignore_idle_after", busy2, 0);

        // start held high: back-to-back frames with one idle cycle between them.
        for (int j = 0; j < 3; j++) exp1.push_back(8'h55);
        set_in(1, 1'b1, 40'h55);
        @(negedge sys_clk);
        check("cont_start_latency", tx1, 0);
        for (int f = 0; f < 3; f++) begin
            n = 1; seen = 1'b0;
            for (int c = 0; c < 1000 && !seen; c++) begin
                @(negedge sys_clk);
                n++;
                if (done1) seen = 1'b1;
            end
            check("cont_frame_len", seen ? n : -1, F * DIV + 1);
            check("cont_done_tx_high", tx1, 1);
            check("cont_done_busy_low", busy1, 0);
            if (f == 2) set_in(1, 1'b0, 40'h55);
            @(negedge sys_clk);
            check("cont_restart_tx", tx1, (f < 2) ? 0 : 1);
        end
        repeat (3) @(negedge sys_clk);
        check("cont_sb_drained", exp1.size(), 0);

        // Reset during byte 2, data bit 3 (a zero bit of 0x04).
        for (int j = 0; j < 5; j++) exp5.push_back(vecs[0].exp[j]);
        set_in(5, 1'b1, vecs[0].data);
        @(negedge sys_clk);
        set_in(5, 1'b0, vecs[0].data);
        repeat (244) @(negedge sys_clk);
        check("rst_pre_tx_low", tx5, 0);
        check("rst_pre_busy", busy5, 1);
        dc = done_cnt5;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_high_async", tx5, 1);
        check("rst_busy_low_async", busy5, 0);
        repeat (15) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_no_done", done_cnt5 - dc, 0);
        check("rst_line_idle", tx5, 1);
        exp5.delete();
        for (int j = 0; j < 5; j++) exp5.push_back(vecs[0].exp[j]);
        run_frame(5, vecs[0].data, 5 * F * DIV + 1);
        repeat (3) @(negedge sys_clk);
        check("rst_refill_drained", exp5.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
